// File: rtl/xc_malu_sequencer.sv
// xc_malu_sequencer
// Accepts one XCrypto multi-precision request at a time, normalises its
// modifiers, and expands it into one or two xc_malu micro-ops. The final
// xc_malu result is captured and returned on a valid/ready response port.
//
// Ports:
//   clock, resetn              core clock, async active-low reset
//   req_*                      request from decode/dispatch (valid/ready)
//   kill                       abandon the in-flight request
//   malu_valid/ready/flush     xc_malu handshake and state clear
//   malu_rs1..3, malu_uop,
//   malu_lh_sign/rh_sign/
//   malu_carryless, malu_pw    registered micro-op payload
//   malu_result                64-bit xc_malu result
//   rsp_valid/ready            response handshake to writeback
//   rsp_rd, rsp_rd_hi          result low/high words
//   rsp_wide, rsp_err          both words written / illegal op
module xc_malu_sequencer (
   input  logic        clock,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic        req_lh_sign,
   input  logic        req_rh_sign,
   input  logic        req_carryless,
   input  logic [4:0]  req_pw,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [31:0] req_rs3,
   input  logic        kill,
   output logic        malu_valid,
   input  logic        malu_ready,
   output logic        malu_flush,
   output logic [31:0] malu_rs1,
   output logic [31:0] malu_rs2,
   output logic [31:0] malu_rs3,
   output logic [10:0] malu_uop,
   output logic        malu_lh_sign,
   output logic        malu_rh_sign,
   output logic        malu_carryless,
   output logic [4:0]  malu_pw,
   input  logic [63:0] malu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rd,
   output logic [31:0] rsp_rd_hi,
   output logic        rsp_wide,
   output logic        rsp_err
);

   localparam int unsigned UOP_W = 11;
   localparam int unsigned PW_W  = 5;
   localparam logic [PW_W-1:0] PW_32 = PW_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE1 = 2'd1,
      ISSUE2 = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t state;
   logic   two_uop;

   // Request decode and modifier normalisation
   logic             op_legal;
   logic             is_divrem;
   logic             is_mulpmul;
   logic             is_pmul;
   logic             n_lh;
   logic             n_rh;
   logic             n_cl;
   logic [PW_W-1:0]  n_pw;
   logic [UOP_W-1:0] n_uop;
   logic             n_two;
   logic             n_wide;

   always_comb begin
      op_legal   = !req_op[3];
      is_divrem  = (req_op == 4'd0) || (req_op == 4'd1);
      is_mulpmul = (req_op == 4'd2) || (req_op == 4'd3);
      is_pmul    = (req_op == 4'd3);
      n_two      = (req_op == 4'd5) || (req_op == 4'd6) || (req_op == 4'd7);
      n_wide     = (req_op == 4'd2) || n_two;

      n_lh = req_lh_sign;
      n_rh = req_rh_sign;
      n_cl = req_carryless && is_mulpmul;
      if (is_divrem) begin
         n_rh = req_lh_sign;
         n_cl = 1'b0;
      end
      // Carry-less arithmetic has no notion of sign
      if (n_cl) begin
         n_lh = 1'b0;
         n_rh = 1'b0;
      end
      n_pw = is_pmul ? req_pw : PW_32;

      // First uop; the second (_2) variant is always the next bit up
      case (req_op[2:0])
         3'd0:    n_uop = UOP_W'(1) << 0;
         3'd1:    n_uop = UOP_W'(1) << 1;
         3'd2:    n_uop = UOP_W'(1) << 2;
         3'd3:    n_uop = UOP_W'(1) << 3;
         3'd4:    n_uop = UOP_W'(1) << 4;
         3'd5:    n_uop = UOP_W'(1) << 5;
         3'd6:    n_uop = UOP_W'(1) << 7;
         default: n_uop = UOP_W'(1) << 9;
      endcase
   end

   // Combinational handshake outputs
   logic in_issue;
   logic malu_hs;

   always_comb begin
      in_issue   = (state == ISSUE1) || (state == ISSUE2);
      malu_hs    = malu_valid && malu_ready;
      req_ready  = (state == IDLE) && !kill;
      malu_flush = (in_issue && kill) ||
                   (malu_hs && ((state == ISSUE2) || ((state == ISSUE1) && !two_uop)));
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         two_uop        <= 1'b0;
         malu_valid     <= 1'b0;
         malu_rs1       <= '0;
         malu_rs2       <= '0;
         malu_rs3       <= '0;
         malu_uop       <= '0;
         malu_lh_sign   <= 1'b0;
         malu_rh_sign   <= 1'b0;
         malu_carryless <= 1'b0;
         malu_pw        <= '0;
         rsp_valid      <= 1'b0;
         rsp_rd         <= '0;
         rsp_rd_hi      <= '0;
         rsp_wide       <= 1'b0;
         rsp_err        <= 1'b0;
      end else if (kill) begin
         state      <= IDLE;
         malu_valid <= 1'b0;
         rsp_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (!op_legal) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_wide  <= 1'b0;
                     rsp_rd    <= '0;
                     rsp_rd_hi <= '0;
                     state     <= RESP;
                  end else begin
                     malu_valid     <= 1'b1;
                     malu_rs1       <= req_rs1;
                     malu_rs2       <= req_rs2;
                     malu_rs3       <= req_rs3;
                     malu_uop       <= n_uop;
                     malu_lh_sign   <= n_lh;
                     malu_rh_sign   <= n_rh;
                     malu_carryless <= n_cl;
                     malu_pw        <= n_pw;
                     two_uop        <= n_two;
                     rsp_wide       <= n_wide;
                     rsp_err        <= 1'b0;
                     state          <= ISSUE1;
                  end
               end
            end
            ISSUE1: begin
               if (malu_ready) begin
                  if (two_uop) begin
                     // First-half result is dropped; xc_malu keeps its accumulator
                     malu_uop <= malu_uop << 1;
                     state    <= ISSUE2;
                  end else begin
                     malu_valid <= 1'b0;
                     rsp_valid  <= 1'b1;
                     rsp_rd     <= malu_result[31:0];
                     rsp_rd_hi  <= malu_result[63:32];
                     state      <= RESP;
                  end
               end
            end
            ISSUE2: begin
               if (malu_ready) begin
                  malu_valid <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_rd     <= malu_result[31:0];
                  rsp_rd_hi  <= malu_result[63:32];
                  state      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/xc_malu_sequencer.md
# xc_malu_sequencer

Issue sequencer that sits directly upstream of `xc_malu`. It accepts one multi-precision arithmetic request at a time from the XCrypto decode/dispatch stage and expands it into one or two `xc_malu` micro-ops. It drives the `xc_malu` valid/ready/flush handshake, captures the 64-bit result, and presents it to writeback through a valid/ready response port.

## Interface
Parameters:
- none

Ports:
- `clock` — in, 1 — core clock; all state updates on the rising edge.
- `resetn` — in, 1 — reset, asynchronous, active-low.
- `req_valid` — in, 1 — request present.
- `req_ready` — out, 1 — request accepted when `req_valid && req_ready`.
- `req_op` — in, 4 — operation:
  - legal: 0 div, 1 rem, 2 mul, 3 pmul, 4 madd, 5 msub, 6 macc, 7 mmul
  - 8–15 are illegal.
- `req_lh_sign`, `req_rh_sign`, `req_carryless` — in, 1 each — operand modifiers.
- `req_pw` — in, 5 — one-hot packed width `{pw_2,pw_4,pw_8,pw_16,pw_32}`.
- `req_rs1`, `req_rs2`, `req_rs3` — in, 32 each — source operands.
- `kill` — in, 1 — abandon the in-flight request.
- `malu_valid` — out, 1 — micro-op presented to `xc_malu`.
- `malu_ready` — in, 1 — `xc_malu` result ready.
- `malu_flush` — out, 1 — clears `xc_malu` internal state.
- `malu_rs1`, `malu_rs2`, `malu_rs3` — out, 32 each — operands.
- `malu_uop` — out, 11 — one-hot, bit i = {div,rem,mul,pmul,madd,msub_1,msub_2,macc_1,macc_2,mmul_1,mmul_2}[i].
- `malu_lh_sign`, `malu_rh_sign`, `malu_carryless` — out, 1 each.
- `malu_pw` — out, 5 — one-hot, same encoding as `req_pw`.
- `malu_result` — in, 64 — `xc_malu` result, sampled on handshake.
- `rsp_valid` — out, 1 — response present.
- `rsp_ready` — in, 1 — writeback accepts the response.
- `rsp_rd` — out, 32 — result[31:0].
- `rsp_rd_hi` — out, 32 — result[63:32].
- `rsp_wide` — out, 1 — both words are architecturally written.
- `rsp_err` — out, 1 — illegal op.

## Operation
FSM states are IDLE, ISSUE1, ISSUE2, RESP.

- **IDLE:** `req_ready = !kill`.
  - On accept, register the operands and normalised modifiers, then go to ISSUE1.
  - Illegal op: go straight to RESP with `rsp_err=1` and `rsp_rd=rsp_rd_hi=0`.
- **ISSUE1:** `malu_valid=1`. The uop is:
  - div/rem/mul/pmul/madd: that op;
  - msub/macc/mmul: the `_1` variant.
  - On `malu_ready`:
    - two-uop ops go to ISSUE2; the uop_1 result is discarded and `malu_flush=0`, so `xc_malu` keeps its accumulator.
    - all others capture `malu_result`, pulse `malu_flush`, and go to RESP.
- **ISSUE2:** `malu_valid=1` with the `_2` uop and the same rs1/rs2/rs3. On `malu_ready`, capture the result, pulse `malu_flush`, and go to RESP.
- **RESP:** `rsp_valid=1`. On `rsp_ready`, go to IDLE.
- **Modifier normalisation:**
  - div/rem force `rh_sign=lh_sign` and `carryless=0`.
  - `carryless` is passed only for mul/pmul and forced to 0 otherwise.
  - `pw` is passed only for pmul and forced to pw_32 otherwise.
  - `carryless` forces both sign bits to 0.
- `rsp_wide=1` for mul, msub, macc and mmul; 0 otherwise.
- **Kill:** from any state, the next state is IDLE and no response is produced.
  - If in ISSUE1/ISSUE2, `malu_flush=1` in the kill cycle.
  - Kill while in RESP drops the response.
  - Kill in IDLE blocks acceptance for that cycle.

## Timing
- **Reset values:** state=IDLE. All outputs are 0 except `req_ready`, which is 1 after reset deassertion when `kill=0`.
- **Asynchronous reset mid-operation:** outputs clear immediately; the in-flight request is lost.
- **`malu_*` stability:** operand and uop outputs are registered and held stable while `malu_valid && !malu_ready`. `malu_valid` never drops without a handshake, except on kill or reset.
- **`rsp_*` stability:** held stable while `rsp_valid && !rsp_ready`.
- **Latency:** request accepted at cycle T → `malu_valid` at T+1.
  - Single-uop op with ready in the same cycle → `rsp_valid` at T+2.
  - Two-uop op with `malu_ready` each at first presentation → `rsp_valid` at T+3.
- **`malu_flush`:** a combinational single-cycle pulse, coincident with the final handshake or with kill.
- **Throughput:** one request in flight. `req_ready=0` outside IDLE; there is no same-cycle RESP→IDLE accept.
- **Kill with `malu_ready` in the same cycle:** kill wins; the result is discarded.

## Test plan
- **div:** `req_op=0`, rs1=100, rs2=7, unsigned; model returns 0x0E after 4 cycles.
  - Exactly one handshake with `malu_uop=1<<0` and `malu_flush` coincident.
  - Response `rsp_rd=14`, `rsp_wide=0`, `rsp_err=0`.
- **macc:** model ready after 3 cycles per uop; second result 0x00000001_00000002.
  - uop bit 7 then bit 8.
  - `malu_flush` only on the second handshake.
  - `rsp_rd_hi=1`, `rsp_rd=2`, `rsp_wide=1`.
- **pmul:** `req_pw=5'b00100`, `req_lh_sign=1`, `req_carryless=1` → `malu_pw=5'b00100`, both signs 0, `malu_carryless=1`.
  - Normalisation check: madd with `req_pw=5'b00010` → `malu_pw=5'b00001`.
- **Response backpressure:** `rsp_ready` low for 5 cycles.
  - `rsp_*` held constant and `req_ready=0` throughout.
  - IDLE one cycle after `rsp_ready` rises.
- **Kill in ISSUE2 (mmul):**
  - `malu_flush=1` in the kill cycle.
  - `malu_valid=0` and `req_ready=1` the next cycle.
  - `rsp_valid` never asserts.
- **Illegal op and reset:**
  - `req_op=12` → `rsp_valid` at T+1 with `rsp_err=1`, `rsp_rd=0`, and no `malu_valid`.
  - `resetn` low mid-ISSUE1 → `malu_valid` and `rsp_valid` go 0 without waiting for a clock edge.
